// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR. One multiplier-accumulator walks a
// circular sample buffer against a coefficient register file, producing
// y[n] = sum_k c[k]*x[n-k] once per accepted sample (TAPS+1 cycles per sample).
//
// Ports
//   clock95            rising-edge clock
//   reset95            asynchronous active-low reset
//   in_valid/in_ready  sample handshake, in_data is the signed sample
//   coef_we/addr/data  coefficient write, honoured only while idle
//   flush              zero the sample buffer (pending if raised mid-MAC)
//   out_valid          one-cycle pulse when out_data carries a new result
//   out_data           signed result, held until the next result
//
// Build option
//   FIR_SEQ_SAT_EN     when defined, every accumulation saturates to the signed
//                      ACC_W range; otherwise accumulation wraps modulo 2^ACC_W.

module fir_mac_coef_rf #(
   parameter int TAPS   = 16,
   parameter int COEF_W = 16,
   parameter int AW     = 4
) (
   input  logic                     clock95,
   input  logic                     reset95,
   input  logic                     we,
   input  logic [AW-1:0]            waddr,
   input  logic signed [COEF_W-1:0] wdata,
   input  logic [AW-1:0]            raddr,
   output logic signed [COEF_W-1:0] rdata
);

   logic signed [COEF_W-1:0] coef [TAPS];

   always_ff @(posedge clock95 or negedge reset95) begin
      if (!reset95) begin
         for (int i = 0; i < TAPS; i++) coef[i] <= '0;
      end else if (we && (int'(waddr) < TAPS)) begin
         coef[waddr] <= wdata;
      end
   end

   assign rdata = (int'(raddr) < TAPS) ? coef[raddr] : '0;

endmodule

// state    | meaning
// ST_FLUSH | zero buffer[cnt] for cnt = 0..TAPS-1, then rewind wr_ptr
// ST_IDLE  | in_ready high; accept a sample, a coefficient write or a flush
// ST_MAC   | cnt = k, acc += c[k] * x[n-k]; result published on k = TAPS-1
module fir_mac_sequencer #(
   parameter  int TAPS   = 16,
   parameter  int DATA_W = 17,
   parameter  int COEF_W = 16,
   parameter  int ACC_W  = 40,
   localparam int AW     = $clog2(TAPS)
) (
   input  logic                     clock95,
   input  logic                     reset95,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     in_ready,
   input  logic                     coef_we,
   input  logic [AW-1:0]            coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   input  logic                     flush,
   output logic                     out_valid,
   output logic signed [ACC_W-1:0]  out_data
);

   localparam int PW = DATA_W + COEF_W;
   localparam int SW = ACC_W + 1;
   localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

   typedef enum logic [1:0] {ST_FLUSH, ST_IDLE, ST_MAC} state_t;

   state_t                   state, state_nxt;
   logic [AW-1:0]            cnt, cnt_nxt;
   logic [AW-1:0]            wr_ptr, wr_ptr_nxt, wr_ptr_inc, rd_idx;
   logic                     flush_pend, flush_pend_nxt;
   logic signed [ACC_W-1:0]  acc, acc_nxt, acc_sum, out_data_nxt;
   logic                     out_valid_nxt;
   logic                     buf_we, coef_wr;
   logic [AW-1:0]            buf_waddr;
   logic signed [DATA_W-1:0] buf_wdata, buf_rd;
   logic signed [COEF_W-1:0] coef_rd;
   logic signed [PW-1:0]     prod;
   logic signed [DATA_W-1:0] sbuf [TAPS];

   fir_mac_coef_rf #(.TAPS(TAPS), .COEF_W(COEF_W), .AW(AW)) u_coef_rf (
      .clock95 (clock95),
      .reset95 (reset95),
      .we      (coef_wr),
      .waddr   (coef_addr),
      .wdata   (coef_data),
      .raddr   (cnt),
      .rdata   (coef_rd)
   );

   // The buffer is cleared by the FLUSH pass that follows every reset.
   always_ff @(posedge clock95) begin
      if (buf_we) sbuf[buf_waddr] <= buf_wdata;
   end

   assign wr_ptr_inc = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
   // Non-power-of-two depths need the explicit wrap; the intermediate may
   // overflow AW bits but the true result is always below TAPS.
   assign rd_idx     = (wr_ptr >= cnt) ? (wr_ptr - cnt) : (wr_ptr + AW'(TAPS) - cnt);
   assign buf_rd     = sbuf[rd_idx];
   assign prod       = PW'(buf_rd) * PW'(coef_rd);

`ifdef FIR_SEQ_SAT_EN
   logic signed [ACC_W:0] sum_wide;

   always_comb begin
      sum_wide = SW'(acc) + SW'(prod);
      if (sum_wide[ACC_W] != sum_wide[ACC_W-1])
         acc_sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         acc_sum = sum_wide[ACC_W-1:0];
   end
`else
   assign acc_sum = acc + ACC_W'(prod);
`endif

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      wr_ptr_nxt     = wr_ptr;
      flush_pend_nxt = flush_pend;
      acc_nxt        = acc;
      out_data_nxt   = out_data;
      out_valid_nxt  = 1'b0;
      buf_we         = 1'b0;
      buf_waddr      = cnt;
      buf_wdata      = '0;
      coef_wr        = 1'b0;
      in_ready       = 1'b0;
      case (state)
         ST_FLUSH: begin
            buf_we  = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST) begin
               cnt_nxt    = '0;
               wr_ptr_nxt = '0;
               state_nxt  = ST_IDLE;
            end
         end
         ST_IDLE: begin
            in_ready = 1'b1;
            coef_wr  = coef_we;
            if (flush) begin
               cnt_nxt   = '0;
               state_nxt = ST_FLUSH;
            end else if (in_valid) begin
               wr_ptr_nxt = wr_ptr_inc;
               buf_we     = 1'b1;
               buf_waddr  = wr_ptr_inc;
               buf_wdata  = in_data;
               acc_nxt    = '0;
               cnt_nxt    = '0;
               state_nxt  = ST_MAC;
            end
         end
         ST_MAC: begin
            acc_nxt = acc_sum;
            cnt_nxt = cnt + 1'b1;
            if (flush) flush_pend_nxt = 1'b1;
            if (cnt == LAST) begin
               out_data_nxt   = acc_sum;
               out_valid_nxt  = 1'b1;
               cnt_nxt        = '0;
               flush_pend_nxt = 1'b0;
               state_nxt      = (flush_pend || flush) ? ST_FLUSH : ST_IDLE;
            end
         end
         default: state_nxt = ST_FLUSH;
      endcase
   end

   always_ff @(posedge clock95 or negedge reset95) begin
      if (!reset95) begin
         state      <= ST_FLUSH;
         cnt        <= '0;
         wr_ptr     <= '0;
         flush_pend <= 1'b0;
         acc        <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         wr_ptr     <= wr_ptr_nxt;
         flush_pend <= flush_pend_nxt;
         acc        <= acc_nxt;
         out_data   <= out_data_nxt;
         out_valid  <= out_valid_nxt;
      end
   end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;

   localparam int ACC4 = 40;
   localparam int ACC5 = 34;

   typedef longint arr8_t [8];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                   d4_in_valid, d4_in_ready, d4_coef_we, d4_flush, d4_out_valid;
   logic signed [16:0]     d4_in_data;
   logic [1:0]             d4_coef_addr;
   logic signed [15:0]     d4_coef_data;
   logic signed [ACC4-1:0] d4_out_data;

   logic                   d5_in_valid, d5_in_ready, d5_coef_we, d5_flush, d5_out_valid;
   logic signed [16:0]     d5_in_data;
   logic [2:0]             d5_coef_addr;
   logic signed [15:0]     d5_coef_data;
   logic signed [ACC5-1:0] d5_out_data;

   fir_mac_sequencer #(.TAPS(4), .DATA_W(17), .COEF_W(16), .ACC_W(ACC4)) dut4 (
      .clock95(clk), .reset95(rst_n),
      .in_valid(d4_in_valid), .in_data(d4_in_data), .in_ready(d4_in_ready),
      .coef_we(d4_coef_we), .coef_addr(d4_coef_addr), .coef_data(d4_coef_data),
      .flush(d4_flush), .out_valid(d4_out_valid), .out_data(d4_out_data)
   );

   fir_mac_sequencer #(.TAPS(5), .DATA_W(17), .COEF_W(16), .ACC_W(ACC5)) dut5 (
      .clock95(clk), .reset95(rst_n),
      .in_valid(d5_in_valid), .in_data(d5_in_data), .in_ready(d5_in_ready),
      .coef_we(d5_coef_we), .coef_addr(d5_coef_addr), .coef_data(d5_coef_data),
      .flush(d5_flush), .out_valid(d5_out_valid), .out_data(d5_out_data)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: coefficient table and sample history, hist[k] = x[n-k].
   arr8_t m4_coef, m4_hist, m5_coef, m5_hist;

   function automatic longint fold(longint a, longint p, int w);
      longint s, hi, lo;
      s  = a + p;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -(longint'(1) <<< (w - 1));
`ifdef FIR_SEQ_SAT_EN
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
`else
      while (s > hi) s = s - (longint'(1) <<< w);
      while (s < lo) s = s + (longint'(1) <<< w);
`endif
      return s;
   endfunction

   function automatic longint conv(int taps, int w, arr8_t c, arr8_t h);
      longint s = 0;
      for (int k = 0; k < taps; k++) s = fold(s, c[k] * h[k], w);
      return s;
   endfunction

   function automatic longint rnd_sample();
      return longint'($urandom_range(0, 131071)) - 65536;
   endfunction

   function automatic longint rnd_coef();
      return longint'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 8; k++) begin
         m4_coef[k] = 0; m4_hist[k] = 0; m5_coef[k] = 0; m5_hist[k] = 0;
      end
   endtask

   task automatic push4(input longint d, output longint y);
      for (int k = 7; k > 0; k--) m4_hist[k] = m4_hist[k-1];
      m4_hist[0] = d;
      y = conv(4, ACC4, m4_coef, m4_hist);
   endtask

   task automatic push5(input longint d, output longint y);
      for (int k = 7; k > 0; k--) m5_hist[k] = m5_hist[k-1];
      m5_hist[0] = d;
      y = conv(5, ACC5, m5_coef, m5_hist);
   endtask

   // All drive/sample activity happens at negedges, away from the active edge.
   task automatic wcoef4(input int a, input longint c);
      for (int i = 0; i < 100 && d4_in_ready !== 1'b1; i++) @(negedge clk);
      d4_coef_we = 1'b1; d4_coef_addr = 2'(a); d4_coef_data = 16'(c);
      @(negedge clk);
      d4_coef_we = 1'b0;
      m4_coef[a] = c;
   endtask

   task automatic wcoef5(input int a, input longint c);
      for (int i = 0; i < 100 && d5_in_ready !== 1'b1; i++) @(negedge clk);
      d5_coef_we = 1'b1; d5_coef_addr = 3'(a); d5_coef_data = 16'(c);
      @(negedge clk);
      d5_coef_we = 1'b0;
      m5_coef[a] = c;
   endtask

   // Offer one sample (optionally with a same-edge coefficient write), then
   // report the result and how many edges after acceptance out_valid showed.
   task automatic do_sample4(input longint d, input bit cw, input int ca, input longint cv,
                             output longint y_exp, output longint got, output int lat);
      for (int i = 0; i < 100 && d4_in_ready !== 1'b1; i++) @(negedge clk);
      d4_in_valid = 1'b1; d4_in_data = 17'(d);
      if (cw) begin
         d4_coef_we = 1'b1; d4_coef_addr = 2'(ca); d4_coef_data = 16'(cv);
         m4_coef[ca] = cv;
      end
      push4(d, y_exp);
      @(negedge clk);
      d4_in_valid = 1'b0; d4_coef_we = 1'b0;
      lat = -1; got = 0;
      for (int n = 1; n <= 50; n++) begin
         @(negedge clk);
         if (d4_out_valid === 1'b1) begin lat = n; got = longint'(d4_out_data); break; end
      end
   endtask

   task automatic do_sample5(input longint d, output longint y_exp, output longint got, output int lat);
      for (int i = 0; i < 100 && d5_in_ready !== 1'b1; i++) @(negedge clk);
      d5_in_valid = 1'b1; d5_in_data = 17'(d);
      push5(d, y_exp);
      @(negedge clk);
      d5_in_valid = 1'b0;
      lat = -1; got = 0;
      for (int n = 1; n <= 50; n++) begin
         @(negedge clk);
         if (d5_out_valid === 1'b1) begin lat = n; got = longint'(d5_out_data); break; end
      end
   endtask

   task automatic test_reset();
      bit er4, er5;
      rst_n = 1'b0;
      d4_in_valid = 0; d4_in_data = 0; d4_coef_we = 0; d4_coef_addr = 0; d4_coef_data = 0; d4_flush = 0;
      d5_in_valid = 0; d5_in_data = 0; d5_coef_we = 0; d5_coef_addr = 0; d5_coef_data = 0; d5_flush = 0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (d4_in_ready !== 1'b0 || d4_out_valid !== 1'b0 || d4_out_data !== '0)
         begin errors++; $display("FAIL reset_values: got ready=%b valid=%b data=%0d, expected 0 0 0", d4_in_ready, d4_out_valid, d4_out_data); end
      rst_n = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         er4 = (n >= 4);
         er5 = (n >= 5);
         checks++;
         if (d4_in_ready !== er4) begin errors++; $display("FAIL reset_ready4 edge %0d: got %b expected %b", n, d4_in_ready, er4); end
         checks++;
         if (d5_in_ready !== er5) begin errors++; $display("FAIL reset_ready5 edge %0d: got %b expected %b", n, d5_in_ready, er5); end
         checks++;
         if (d4_out_valid !== 1'b0 || d4_out_data !== '0) begin errors++; $display("FAIL reset_outputs edge %0d: got valid=%b data=%0d expected 0 0", n, d4_out_valid, d4_out_data); end
      end
   endtask

   task automatic test_impulse();
      longint ins [5];
      longint e, g;
      int lat;
      ins = '{1, 0, 0, 0, 0};
      for (int i = 0; i < 4; i++) wcoef4(i, i + 1);
      foreach (ins[i]) begin
         do_sample4(ins[i], 1'b0, 0, 0, e, g, lat);
         checks++;
         if (g !== e) begin errors++; $display("FAIL impulse_out[%0d]: got %0d expected %0d", i, g, e); end
         checks++;
         if (lat !== 4) begin errors++; $display("FAIL impulse_latency[%0d]: got %0d expected 4", i, lat); end
         checks++;
         if (d4_in_ready !== 1'b1) begin errors++; $display("FAIL impulse_ready_with_out[%0d]: got %b expected 1", i, d4_in_ready); end
         @(negedge clk);
         checks++;
         if (d4_out_valid !== 1'b0 || longint'(d4_out_data) !== e)
            begin errors++; $display("FAIL impulse_pulse_hold[%0d]: got valid=%b data=%0d expected 0 %0d", i, d4_out_valid, d4_out_data, e); end
      end
   endtask

   task automatic test_neg_step();
      longint e, g;
      int lat;
      for (int i = 0; i < 4; i++) wcoef4(i, 1);
      for (int n = 0; n < 10; n++) begin
         do_sample4(-2, 1'b0, 0, 0, e, g, lat);
         checks++;
         if (g !== e) begin errors++; $display("FAIL neg_step_out[%0d]: got %0d expected %0d", n, g, e); end
      end
   endtask

   task automatic test_gating();
      int     acc_cyc [$];
      longint exp_q [$];
      longint got_q [$];
      longint e, cur;
      bit     acc_now;
      for (int i = 0; i < 4; i++) wcoef4(i, i + 1);
      cur = rnd_sample();
      d4_in_valid = 1'b1; d4_in_data = 17'(cur);
      for (int cyc = 0; cyc < 20; cyc++) begin
         acc_now = (d4_in_ready === 1'b1);
         if (acc_now) begin
            push4(cur, e); exp_q.push_back(e); acc_cyc.push_back(cyc);
            d4_coef_we = 1'b0;
         end else begin
            d4_coef_we = 1'b1; d4_coef_addr = 2'd0; d4_coef_data = 16'sd7;
         end
         @(negedge clk);
         if (d4_out_valid === 1'b1) got_q.push_back(longint'(d4_out_data));
         if (acc_now) begin cur = rnd_sample(); d4_in_data = 17'(cur); end
      end
      d4_in_valid = 1'b0; d4_coef_we = 1'b0;
      checks++;
      if (acc_cyc.size() !== 4) begin errors++; $display("FAIL gating_accepts: got %0d expected 4", acc_cyc.size()); end
      for (int i = 1; i < acc_cyc.size(); i++) begin
         checks++;
         if (acc_cyc[i] - acc_cyc[i-1] !== 5)
            begin errors++; $display("FAIL gating_interval[%0d]: got %0d expected 5", i, acc_cyc[i] - acc_cyc[i-1]); end
      end
      checks++;
      if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL gating_out_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL gating_out[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_random();
      longint e, g, cv, d;
      int lat, ca;
      bit cw;
      for (int i = 0; i < 4; i++) wcoef4(i, rnd_coef());
      for (int n = 0; n < 12; n++) begin
         cw = ($urandom_range(0, 3) == 0);
         ca = int'($urandom_range(0, 3));
         cv = rnd_coef();
         d  = rnd_sample();
         do_sample4(d, cw, ca, cv, e, g, lat);
         checks++;
         if (g !== e) begin errors++; $display("FAIL random_out[%0d]: got %0d expected %0d", n, g, e); end
         checks++;
         if (lat !== 4) begin errors++; $display("FAIL random_latency[%0d]: got %0d expected 4", n, lat); end
      end
   endtask

   task automatic test_flush();
      longint e, g;
      int lat;
      bit er;
      for (int i = 0; i < 4; i++) wcoef4(i, i + 1);
      for (int n = 0; n < 4; n++) begin
         do_sample4(9, 1'b0, 0, 0, e, g, lat);
         checks++;
         if (g !== e) begin errors++; $display("FAIL flush_fill[%0d]: got %0d expected %0d", n, g, e); end
      end
      // Flush raised on the first MAC edge of the next sample.
      for (int i = 0; i < 100 && d4_in_ready !== 1'b1; i++) @(negedge clk);
      d4_in_valid = 1'b1; d4_in_data = 17'sd9;
      push4(9, e);
      @(negedge clk);
      d4_in_valid = 1'b0; d4_flush = 1'b1;
      @(negedge clk);
      d4_flush = 1'b0;
      lat = -1; g = 0;
      for (int n = 2; n <= 50; n++) begin
         @(negedge clk);
         if (d4_out_valid === 1'b1) begin lat = n; g = longint'(d4_out_data); break; end
      end
      checks++;
      if (g !== e) begin errors++; $display("FAIL flush_mac_out: got %0d expected %0d", g, e); end
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL flush_mac_latency: got %0d expected 4", lat); end
      checks++;
      if (d4_in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_at_out: got %b expected 0", d4_in_ready); end
      // A coefficient write during the flush must be dropped.
      d4_coef_we = 1'b1; d4_coef_addr = 2'd0; d4_coef_data = 16'sd7;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         er = (n == 4);
         checks++;
         if (d4_in_ready !== er) begin errors++; $display("FAIL flush_ready[%0d]: got %b expected %b", n, d4_in_ready, er); end
      end
      d4_coef_we = 1'b0;
      for (int k = 0; k < 8; k++) m4_hist[k] = 0;
      do_sample4(5, 1'b0, 0, 0, e, g, lat);
      checks++;
      if (g !== e) begin errors++; $display("FAIL flush_after_out: got %0d expected %0d", g, e); end
      // Flush in IDLE wins over a simultaneous sample.
      d4_flush = 1'b1; d4_in_valid = 1'b1; d4_in_data = 17'sd77;
      @(negedge clk);
      d4_flush = 1'b0; d4_in_valid = 1'b0;
      checks++;
      if (d4_in_ready !== 1'b0) begin errors++; $display("FAIL idle_flush_ready: got %b expected 0", d4_in_ready); end
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         er = (n == 4);
         checks++;
         if (d4_in_ready !== er || d4_out_valid !== 1'b0)
            begin errors++; $display("FAIL idle_flush_cycle[%0d]: got ready=%b valid=%b expected %b 0", n, d4_in_ready, d4_out_valid, er); end
      end
      for (int k = 0; k < 8; k++) m4_hist[k] = 0;
      do_sample4(3, 1'b0, 0, 0, e, g, lat);
      checks++;
      if (g !== e) begin errors++; $display("FAIL idle_flush_after: got %0d expected %0d", g, e); end
   endtask

   task automatic test_reset_mid();
      longint e, g;
      int lat;
      for (int i = 0; i < 100 && d4_in_ready !== 1'b1; i++) @(negedge clk);
      d4_in_valid = 1'b1; d4_in_data = 17'sd10;
      @(negedge clk);
      d4_in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (d4_in_ready !== 1'b0 || d4_out_valid !== 1'b0 || d4_out_data !== '0)
         begin errors++; $display("FAIL reset_mid_values: got ready=%b valid=%b data=%0d expected 0 0 0", d4_in_ready, d4_out_valid, d4_out_data); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      do_sample4(3, 1'b0, 0, 0, e, g, lat);
      checks++;
      if (g !== e) begin errors++; $display("FAIL reset_mid_coef_cleared: got %0d expected %0d", g, e); end
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL reset_mid_latency: got %0d expected 4", lat); end
   endtask

   task automatic test_saturation();
      longint e, g;
      int lat;
      for (int i = 0; i < 5; i++) wcoef5(i, 32767);
      for (int n = 0; n < 4; n++) begin
         do_sample5(65535, e, g, lat);
         checks++;
         if (g !== e) begin errors++; $display("FAIL sat_fill[%0d]: got %0d expected %0d", n, g, e); end
         checks++;
         if (lat !== 5) begin errors++; $display("FAIL sat_latency[%0d]: got %0d expected 5", n, lat); end
      end
      wcoef5(0, -32768);
      do_sample5(-65536, e, g, lat);
      checks++;
      if (g !== e) begin errors++; $display("FAIL sat_peak: got %0d expected %0d", g, e); end
      do_sample5(-65536, e, g, lat);
      checks++;
      if (g !== e) begin errors++; $display("FAIL sat_next: got %0d expected %0d", g, e); end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_neg_step();
      test_gating();
      test_random();
      test_flush();
      test_reset_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
